// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared constants for the adder seven-segment display
package rca_pkg;

  // Digit slot assignments, scanned in index order 0..3
  localparam logic [1:0] DIG_SUM  = 2'd0;
  localparam logic [1:0] DIG_COUT = 2'd1;
  localparam logic [1:0] DIG_B    = 2'd2;
  localparam logic [1:0] DIG_A    = 2'd3;

  // All cathodes off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex digit to cathode pattern {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex digit to active-low seven-segment decoder
module hex_to_seg7
  import rca_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/rca_seg_display.sv
// rtl/rca_seg_display.sv - multiplexed 4-digit display of adder A, B, carry and SUM (optional operand latching: RCA_SEG_LATCH_EN)
module rca_seg_display
  import rca_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] sum_i,
  input  logic       cout_i,
  input  logic       load_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] an_o
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          tick;

  logic [3:0]    a_v, b_v, sum_v;
  logic          cout_v;
  logic [3:0]    hex_sel;
  logic [6:0]    seg_dec;

  logic [6:0]    seg_q;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  assign tick = (cnt_q == CW'(REFRESH_DIV - 1));

`ifdef RCA_SEG_LATCH_EN
  logic [3:0] a_q, b_q, sum_q;
  logic       cout_q;

  // Capture operands on load; the view bypasses the hold so a capture lands in the same output update
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      sum_q  <= 4'd0;
      cout_q <= 1'b0;
    end else if (load_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      sum_q  <= sum_i;
      cout_q <= cout_i;
    end
  end

  assign a_v    = load_i ? a_i    : a_q;
  assign b_v    = load_i ? b_i    : b_q;
  assign sum_v  = load_i ? sum_i  : sum_q;
  assign cout_v = load_i ? cout_i : cout_q;
`else
  logic unused_load;
  assign unused_load = load_i;

  assign a_v    = a_i;
  assign b_v    = b_i;
  assign sum_v  = sum_i;
  assign cout_v = cout_i;
`endif

  // Prescaler and digit index next state; index advances on the last clock of each slot
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;
  end

  // Select the hex value for the digit currently indexed
  always_comb begin
    hex_sel = 4'd0;
    case (idx_q)
      DIG_SUM:  hex_sel = sum_v;
      DIG_COUT: hex_sel = {3'b000, cout_v};
      DIG_B:    hex_sel = b_v;
      default:  hex_sel = a_v;
    endcase
  end

  hex_to_seg7 u_dec (
    .hex_i (hex_sel),
    .seg_o (seg_dec)
  );

  // Anode and decimal point for the indexed digit; dp flags a carry on the SUM digit
  always_comb begin
    an_d = ~(4'b0001 << idx_q);
    dp_d = ~((idx_q == DIG_SUM) && cout_v);
  end

  // State and output registers; outputs trail the index by one clock and blank in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= DIG_SUM;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= 4'b1111;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_dec;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_rca_seg_display.sv
// tb/tb_rca_seg_display.sv - self-checking bench for rca_seg_display with REFRESH_DIV=4
module tb_rca_seg_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a_i = 4'd0;
  logic [3:0] b_i = 4'd0;
  logic [3:0] sum_i = 4'd0;
  logic       cout_i = 1'b0;
  logic       load_i = 1'b0;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [3:0] an_o;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  int         m_cnt = 0;
  int         m_idx = 0;
  logic [3:0] m_a = 0, m_b = 0, m_s = 0;
  logic       m_c = 0;
  logic [11:0] exp_q[$];

  rca_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_i    (a_i),
    .b_i    (b_i),
    .sum_i  (sum_i),
    .cout_i (cout_i),
    .load_i (load_i),
    .seg_o  (seg_o),
    .dp_o   (dp_o),
    .an_o   (an_o)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // One clock: predict the output update, clock the DUT, advance the model, compare
  task automatic step();
    logic [3:0]  va, vb, vs, hx;
    logic        vc;
    logic [3:0]  an_e;
    logic [11:0] e, got;
`ifdef RCA_SEG_LATCH_EN
    va = load_i ? a_i : m_a;
    vb = load_i ? b_i : m_b;
    vs = load_i ? sum_i : m_s;
    vc = load_i ? cout_i : m_c;
`else
    va = a_i; vb = b_i; vs = sum_i; vc = cout_i;
`endif
    if (rst) begin
      e = {4'b1111, 7'b1111111, 1'b1};
    end else begin
      case (m_idx)
        0: hx = vs;
        1: hx = {3'b000, vc};
        2: hx = vb;
        default: hx = va;
      endcase
      an_e = 4'b1111;
      an_e[m_idx] = 1'b0;
      e = {an_e, ref_seg(hx), ~((m_idx == 0) && vc)};
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_a = 0; m_b = 0; m_s = 0; m_c = 0;
    end else begin
      if (load_i) begin m_a = a_i; m_b = b_i; m_s = sum_i; m_c = cout_i; end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    #1;
    got = {an_o, seg_o, dp_o};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL scoreboard t=%0t got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
               $time, got[11:8], got[7:1], got[0], e[11:8], e[7:1], e[0]);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if (an_o !== 4'b1111 || seg_o !== 7'b1111111 || dp_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_blank an=%b seg=%b dp=%b exp 1111 1111111 1", an_o, seg_o, dp_o);
    end
    step();
    n_checks++;
    if (an_o !== 4'b1110) begin
      n_fail++;
      $display("FAIL first_edge_digit0 an=%b exp 1110", an_o);
    end
    repeat (4) step();
    n_checks++;
    if (an_o !== 4'b1101) begin
      n_fail++;
      $display("FAIL slot1_after_4 an=%b exp 1101", an_o);
    end
  endtask

  task automatic test_digits();
    logic [6:0] want;
    a_i = 4'h3; b_i = 4'h4; sum_i = 4'h7; cout_i = 1'b0;
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      step();
      case (an_o)
        4'b1110: want = 7'b1111000;
        4'b1101: want = 7'b1000000;
        4'b1011: want = 7'b0011001;
        4'b0111: want = 7'b0110000;
        default: want = 7'bxxxxxxx;
      endcase
      n_checks++;
      if (seg_o !== want || dp_o !== 1'b1) begin
        n_fail++;
        $display("FAIL digits_347 i=%0d an=%b seg=%b dp=%b exp seg=%b dp=1", i, an_o, seg_o, dp_o, want);
      end
    end
  endtask

  task automatic test_carry();
    logic [6:0] want;
    logic       want_dp;
    a_i = 4'hF; b_i = 4'h1; sum_i = 4'h0; cout_i = 1'b1;
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      step();
      want_dp = (an_o == 4'b1110) ? 1'b0 : 1'b1;
      case (an_o)
        4'b1110: want = 7'b1000000;
        4'b1101: want = 7'b1111001;
        4'b1011: want = 7'b1111001;
        4'b0111: want = 7'b0001110;
        default: want = 7'bxxxxxxx;
      endcase
      n_checks++;
      if (seg_o !== want || dp_o !== want_dp) begin
        n_fail++;
        $display("FAIL carry_digits i=%0d an=%b seg=%b dp=%b exp seg=%b dp=%b", i, an_o, seg_o, dp_o, want, want_dp);
      end
    end
  endtask

`ifdef RCA_SEG_LATCH_EN
  task automatic test_latch();
    logic [6:0] want;
    do_reset(1);
    a_i = 4'h5; b_i = 4'h2; sum_i = 4'h7; cout_i = 1'b0; load_i = 1'b1;
    step();
    load_i = 1'b0;
    a_i = 4'h0; b_i = 4'h0; sum_i = 4'h0; cout_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      case (an_o)
        4'b1110: want = 7'b1111000;
        4'b1101: want = 7'b1000000;
        4'b1011: want = 7'b0100100;
        4'b0111: want = 7'b0010010;
        default: want = 7'bxxxxxxx;
      endcase
      n_checks++;
      if (seg_o !== want) begin
        n_fail++;
        $display("FAIL latch_hold i=%0d an=%b seg=%b exp %b", i, an_o, seg_o, want);
      end
    end
  endtask
`endif

  task automatic test_mid_reset();
    int budget;
    a_i = 4'h9; b_i = 4'hA; sum_i = 4'h3; cout_i = 1'b1;
    do_reset(1);
    budget = 0;
    step();
    while (an_o !== 4'b1011 && budget < 20) begin
      step();
      budget++;
    end
    n_checks++;
    if (an_o !== 4'b1011) begin
      n_fail++;
      $display("FAIL reach_slot2 an=%b exp 1011 within 20 clocks", an_o);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (an_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL mid_reset_blank an=%b exp 1111", an_o);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (an_o !== 4'b1110) begin
        n_fail++;
        $display("FAIL post_reset_slot0 i=%0d an=%b exp 1110", i, an_o);
      end
    end
    step();
    n_checks++;
    if (an_o !== 4'b1101) begin
      n_fail++;
      $display("FAIL post_reset_slot1 an=%b exp 1101", an_o);
    end
  endtask

  task automatic test_onehot_wrap();
    logic [3:0] prev;
    int         wraps;
    a_i = 4'hC; b_i = 4'hD; sum_i = 4'hE; cout_i = 1'b0;
    wraps = 0;
    prev = an_o;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if ($countones(~an_o) != 1) begin
        n_fail++;
        $display("FAIL onehot i=%0d an=%b exp exactly one low bit", i, an_o);
      end
      if (prev == 4'b0111 && an_o == 4'b1110) wraps++;
      prev = an_o;
    end
    n_checks++;
    if (wraps < 2) begin
      n_fail++;
      $display("FAIL index_wrap saw %0d wraps 3->0, exp at least 2", wraps);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_carry();
`ifdef RCA_SEG_LATCH_EN
    test_latch();
`endif
    test_mid_reset();
    test_onehot_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
